// File: rtl/spi_ram_master.sv
// SPI mode-0 master for the on-board SPI RAM framing:
//   command byte (0x00 write / 0x01 read), big-endian address,
//   optional dummy byte on reads, then a stream of data bytes.
// System side uses a simple byte handshake (tx_ready / rx_valid).
// Optional feature macro: SPI_RAM_MASTER_DUMMY_EN inserts one 0x00 dummy
// byte after the address on read transactions (slave read turnaround).
module spi_ram_master #(
    parameter int c_addr_bits = 32,
    parameter int c_clk_div   = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic                   cmd_read,
    input  logic [c_addr_bits-1:0] addr,
    input  logic [15:0]            len,
    input  logic [7:0]             tx_data,
    output logic                   tx_ready,
    output logic [7:0]             rx_data,
    output logic                   rx_valid,
    output logic                   busy,
    output logic                   done,
    output logic                   spi_csn,
    output logic                   spi_sclk,
    output logic                   spi_mosi,
    input  logic                   spi_miso
);

    localparam int c_nab = c_addr_bits / 8;
    localparam int c_cw  = $clog2(2 * c_clk_div + 1);
    localparam logic [c_cw-1:0] c_half_m1    = c_cw'(c_clk_div - 1);
    localparam logic [c_cw-1:0] c_gap_m1     = c_cw'(2 * c_clk_div - 1);
    localparam logic [1:0]      c_last_abyte = 2'(c_nab - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CMD   = 3'd1,
        S_ADDR  = 3'd2,
`ifdef SPI_RAM_MASTER_DUMMY_EN
        S_DUMMY = 3'd3,
`endif
        S_DATA  = 3'd4,
        S_END   = 3'd5,
        S_GAP   = 3'd6
    } t_state;

    t_state                 r_state, w_state;
    logic [c_cw-1:0]        r_div, w_div;
    logic                   r_sclk, w_sclk;
    logic                   r_mosi, w_mosi;
    logic                   r_csn, w_csn;
    logic                   r_busy, w_busy;
    logic                   r_done, w_done;
    logic                   r_tx_ready, w_tx_ready;
    logic                   r_rx_valid, w_rx_valid;
    logic [7:0]             r_rx_data, w_rx_data;
    logic [6:0]             r_rx_sh, w_rx_sh;
    logic [7:0]             r_sh, w_sh;
    logic [2:0]             r_bit, w_bit;
    logic [1:0]             r_abyte, w_abyte;
    logic [c_addr_bits-1:0] r_addr, w_addr;
    logic [15:0]            r_len, w_len;
    logic                   r_read, w_read;
    logic                   w_half;
    logic                   w_load;
    logic [7:0]             w_load_byte;
    logic                   w_enter;

    // Next-state and next-output computation for the whole frame sequencer.
    always_comb begin
        w_state     = r_state;
        w_div       = r_div;
        w_sclk      = r_sclk;
        w_mosi      = r_mosi;
        w_csn       = r_csn;
        w_busy      = r_busy;
        w_done      = 1'b0;
        w_tx_ready  = 1'b0;
        w_rx_valid  = 1'b0;
        w_rx_data   = r_rx_data;
        w_rx_sh     = r_rx_sh;
        w_sh        = r_sh;
        w_bit       = r_bit;
        w_abyte     = r_abyte;
        w_addr      = r_addr;
        w_len       = r_len;
        w_read      = r_read;
        w_half      = (r_div == c_half_m1);
        w_load      = 1'b0;
        w_load_byte = 8'h00;
        w_enter     = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_read  = cmd_read;
                    w_addr  = addr;
                    w_len   = len;
                    w_state = S_CMD;
                    w_csn   = 1'b0;
                    w_busy  = 1'b1;
                    w_div   = {c_cw{1'b0}};
                    w_bit   = 3'd0;
                    // command is 0x00 or 0x01, so bit 7 is always zero
                    w_mosi  = 1'b0;
                    w_sh    = {6'b000000, cmd_read, 1'b0};
                end else begin
                    w_div   = {c_cw{1'b0}};
                end
            end
            S_CMD, S_ADDR,
`ifdef SPI_RAM_MASTER_DUMMY_EN
            S_DUMMY,
`endif
            S_DATA: begin
                if (w_half) begin
                    w_div = {c_cw{1'b0}};
                    if (!r_sclk) begin
                        // rising SCLK: sample MISO on this very edge
                        w_sclk  = 1'b1;
                        w_rx_sh = {r_rx_sh[5:0], spi_miso};
                        if ((r_state == S_DATA) && r_read && (r_bit == 3'd7)) begin
                            w_rx_data  = {r_rx_sh, spi_miso};
                            w_rx_valid = 1'b1;
                        end else begin
                            w_rx_valid = 1'b0;
                        end
                    end else begin
                        // falling SCLK: advance MOSI to the next bit
                        w_sclk = 1'b0;
                        if (r_bit == 3'd7) begin
                            w_bit = 3'd0;
                            case (r_state)
                                S_CMD: begin
                                    w_state     = S_ADDR;
                                    w_load      = 1'b1;
                                    w_load_byte = r_addr[c_addr_bits-1 -: 8];
                                    w_addr      = r_addr << 8;
                                    w_abyte     = c_last_abyte;
                                end
                                S_ADDR: begin
                                    if (r_abyte != 2'd0) begin
                                        w_load      = 1'b1;
                                        w_load_byte = r_addr[c_addr_bits-1 -: 8];
                                        w_addr      = r_addr << 8;
                                        w_abyte     = r_abyte - 2'd1;
                                    end else begin
`ifdef SPI_RAM_MASTER_DUMMY_EN
                                        if (r_read) begin
                                            w_state     = S_DUMMY;
                                            w_load      = 1'b1;
                                            w_load_byte = 8'h00;
                                        end else begin
                                            w_enter = 1'b1;
                                        end
`else
                                        w_enter = 1'b1;
`endif
                                    end
                                end
`ifdef SPI_RAM_MASTER_DUMMY_EN
                                S_DUMMY: w_enter = 1'b1;
`endif
                                S_DATA: begin
                                    w_len   = r_len - 16'd1;
                                    w_enter = 1'b1;
                                end
                                default: w_state = S_END;
                            endcase
                        end else begin
                            w_bit  = r_bit + 3'd1;
                            w_mosi = r_sh[7];
                            w_sh   = {r_sh[6:0], 1'b0};
                        end
                    end
                end else begin
                    w_div = r_div + c_cw'(1);
                end
            end
            S_END: begin
                if (w_half) begin
                    w_csn   = 1'b1;
                    w_done  = 1'b1;
                    w_state = S_GAP;
                    w_div   = {c_cw{1'b0}};
                end else begin
                    w_div = r_div + c_cw'(1);
                end
            end
            S_GAP: begin
                if (r_div == c_gap_m1) begin
                    w_busy  = 1'b0;
                    w_state = S_IDLE;
                    w_div   = {c_cw{1'b0}};
                end else begin
                    w_div = r_div + c_cw'(1);
                end
            end
            default: begin
                w_state = S_IDLE;
                w_csn   = 1'b1;
                w_sclk  = 1'b0;
                w_mosi  = 1'b0;
                w_busy  = 1'b0;
                w_div   = {c_cw{1'b0}};
            end
        endcase

        // header finished or a data byte finished: next data byte or wind down
        if (w_enter) begin
            if (w_len == 16'd0) begin
                w_state = S_END;
                w_mosi  = 1'b0;
                w_sh    = 8'h00;
            end else begin
                w_state = S_DATA;
                w_load  = 1'b1;
                if (r_read) begin
                    w_load_byte = 8'h00;
                end else begin
                    w_load_byte = tx_data;
                    w_tx_ready  = 1'b1;
                end
            end
        end else begin
            w_tx_ready = w_tx_ready;
        end

        if (w_load) begin
            w_mosi = w_load_byte[7];
            w_sh   = {w_load_byte[6:0], 1'b0};
        end else begin
            w_load_byte = w_load_byte;
        end
    end

    // State and output registers; async reset returns pins to idle at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_div      <= {c_cw{1'b0}};
            r_sclk     <= 1'b0;
            r_mosi     <= 1'b0;
            r_csn      <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_tx_ready <= 1'b0;
            r_rx_valid <= 1'b0;
            r_rx_data  <= 8'h00;
            r_rx_sh    <= 7'h00;
            r_sh       <= 8'h00;
            r_bit      <= 3'd0;
            r_abyte    <= 2'd0;
            r_addr     <= {c_addr_bits{1'b0}};
            r_len      <= 16'd0;
            r_read     <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_div      <= w_div;
            r_sclk     <= w_sclk;
            r_mosi     <= w_mosi;
            r_csn      <= w_csn;
            r_busy     <= w_busy;
            r_done     <= w_done;
            r_tx_ready <= w_tx_ready;
            r_rx_valid <= w_rx_valid;
            r_rx_data  <= w_rx_data;
            r_rx_sh    <= w_rx_sh;
            r_sh       <= w_sh;
            r_bit      <= w_bit;
            r_abyte    <= w_abyte;
            r_addr     <= w_addr;
            r_len      <= w_len;
            r_read     <= w_read;
        end
    end

    assign spi_csn  = r_csn;
    assign spi_sclk = r_sclk;
    assign spi_mosi = r_mosi;
    assign busy     = r_busy;
    assign done     = r_done;
    assign tx_ready = r_tx_ready;
    assign rx_valid = r_rx_valid;
    assign rx_data  = r_rx_data;

endmodule

// File: tb/tb_spi_ram_master.sv
// Self-checking bench for spi_ram_master: SPI slave model on the pins,
// reference byte stream built from the framing rules, random payloads.
module tb_spi_ram_master;

    localparam int c_clk_div = 2;
`ifdef SPI_RAM_MASTER_DUMMY_EN
    localparam int c_dummy = 1;
`else
    localparam int c_dummy = 0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        cmd_read;
    logic [31:0] addr;
    logic [15:0] len;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        busy;
    logic        done;
    logic        spi_csn;
    logic        spi_sclk;
    logic        spi_mosi;
    logic        spi_miso = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    int         sclk_pulses = 0;
    logic [7:0] mosi_bytes [$];
    logic [7:0] slave_bytes [$];
    int         slave_hdr_bits = 0;
    logic [7:0] pay_q [$];

    spi_ram_master #(.c_addr_bits(32), .c_clk_div(c_clk_div)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .cmd_read(cmd_read),
        .addr(addr), .len(len), .tx_data(tx_data), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy), .done(done),
        .spi_csn(spi_csn), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso)
    );

    always #5 clk = ~clk;

    // Pin monitor: count SCLK pulses and assemble MOSI bytes (mode 0, sample on rise).
    logic [7:0] mon_sh = 8'h00;
    int         mon_nb = 0;
    always @(posedge spi_sclk or posedge spi_csn) begin
        if (spi_csn === 1'b1) begin
            mon_nb = 0;
        end else begin
            sclk_pulses++;
            mon_sh = {mon_sh[6:0], spi_mosi};
            mon_nb++;
            if (mon_nb == 8) begin
                mosi_bytes.push_back(mon_sh);
                mon_nb = 0;
            end
        end
    end

    function automatic logic miso_bit(input int n);
        int k;
        logic [7:0] b;
        if (n < slave_hdr_bits) return 1'b0;
        k = (n - slave_hdr_bits) / 8;
        if (k >= slave_bytes.size()) return 1'b0;
        b = slave_bytes[k];
        return b[7 - ((n - slave_hdr_bits) % 8)];
    endfunction

    // Slave model: present bit 0 when CSn falls, next bit after each SCLK fall.
    bit last_csn = 1'b1;
    int s_bit = 0;
    always @(negedge spi_csn or posedge spi_csn or negedge spi_sclk) begin
        if (spi_csn !== 1'b0) s_bit = 0;
        else if (last_csn) s_bit = 0;
        else s_bit++;
        spi_miso = (spi_csn === 1'b0) ? miso_bit(s_bit) : 1'b0;
        last_csn = (spi_csn !== 1'b0);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fill_random(input int n);
        pay_q = {};
        for (int i = 0; i < n; i++) pay_q.push_back(8'($urandom));
    endtask

    // One transaction against the reference frame built from pay_q.
    task automatic run_txn(input bit rd, input logic [31:0] a, input int inj_at);
        logic [7:0] exp_q [$];
        logic [7:0] wq [$];
        logic [7:0] rx_obs [$];
        logic [7:0] b;
        int n, p0, q0, cyc, tx_k, n_done, gap;
        bit got_done;
        n = pay_q.size();
        exp_q.push_back(rd ? 8'h01 : 8'h00);
        for (int i = 3; i >= 0; i--) exp_q.push_back(a[8*i +: 8]);
        if (rd) begin
            for (int i = 0; i < c_dummy; i++) exp_q.push_back(8'h00);
        end
        slave_bytes = {};
        for (int i = 0; i < n; i++) begin
            if (rd) begin
                slave_bytes.push_back(pay_q[i]);
                exp_q.push_back(8'h00);
            end else begin
                wq.push_back(pay_q[i]);
                exp_q.push_back(pay_q[i]);
            end
        end
        slave_hdr_bits = 8 * (5 + (rd ? c_dummy : 0));
        p0 = sclk_pulses;
        q0 = mosi_bytes.size();

        @(negedge clk);
        start = 1'b1; cmd_read = rd; addr = a; len = 16'(n);
        tx_data = (!rd && n > 0) ? wq[0] : 8'h00;
        @(negedge clk);
        start = 1'b0; cmd_read = ~rd; addr = ~a; len = 16'hFFFF;
        chk("busy_rise", {31'd0, busy}, 32'd1);

        cyc = 0; got_done = 1'b0; tx_k = 0; n_done = 0;
        while (!got_done && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            start = (cyc == inj_at);
            if (tx_ready) begin
                b = (tx_k < wq.size()) ? wq[tx_k] : 8'h00;
                chk("tx_mosi_bit7", {31'd0, spi_mosi}, {31'd0, b[7]});
                tx_k++;
                tx_data = (tx_k < wq.size()) ? wq[tx_k] : 8'h00;
            end
            if (rx_valid) rx_obs.push_back(rx_data);
            if (done) begin
                got_done = 1'b1;
                chk("csn_at_done", {31'd0, spi_csn}, 32'd1);
            end
        end
        start = 1'b0;
        chk("done_seen", {31'd0, got_done}, 32'd1);

        gap = 0;
        while (busy && gap < 100) begin
            @(negedge clk);
            gap++;
            if (done) n_done++;
        end
        chk("gap_cycles", gap, 2 * c_clk_div);
        chk("done_once", n_done, 0);
        repeat (3 * c_clk_div) @(negedge clk);
        chk("no_queued_txn", {31'd0, spi_csn}, 32'd1);

        chk("sclk_pulses", sclk_pulses - p0, 8 * exp_q.size());
        chk("mosi_nbytes", mosi_bytes.size() - q0, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (q0 + i < mosi_bytes.size()) chk("mosi_byte", {24'd0, mosi_bytes[q0+i]}, {24'd0, exp_q[i]});
        end
        chk("tx_ready_cnt", tx_k, rd ? 0 : n);
        chk("rx_valid_cnt", rx_obs.size(), rd ? n : 0);
        for (int i = 0; i < rx_obs.size(); i++) begin
            if (i < n) chk("rx_data", {24'd0, rx_obs[i]}, {24'd0, pay_q[i]});
        end
    endtask

    initial begin
        int cyc, p0, n_done;
        reset_n = 1'b0; start = 1'b0; cmd_read = 1'b0; addr = 32'd0; len = 16'd0; tx_data = 8'h00;

        // reset values
        repeat (2) @(negedge clk);
        chk("rst_csn", {31'd0, spi_csn}, 32'd1);
        chk("rst_sclk", {31'd0, spi_sclk}, 32'd0);
        chk("rst_mosi", {31'd0, spi_mosi}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_tx_ready", {31'd0, tx_ready}, 32'd0);
        chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        chk("rst_rx_data", {24'd0, rx_data}, 32'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_csn", {31'd0, spi_csn}, 32'd1);

        // directed frames
        pay_q = {8'hA5, 8'h3C};
        run_txn(1'b0, 32'h0000_4000, 0);
        pay_q = {8'h11, 8'h22, 8'h33};
        run_txn(1'b1, 32'h0000_1234, 0);
        pay_q = {};
        run_txn(1'b0, 32'hFF00_0000, 0);

        // start pulses while busy must be ignored
        fill_random(3);
        run_txn(1'b0, $urandom, 30);
        fill_random(2);
        run_txn(1'b1, $urandom, 45);

        // reset in the middle of the address phase
        fill_random(3);
        @(negedge clk);
        start = 1'b1; cmd_read = 1'b0; addr = 32'hDEAD_BEEF; len = 16'd3; tx_data = pay_q[0];
        @(negedge clk);
        start = 1'b0;
        p0 = sclk_pulses; cyc = 0;
        while ((sclk_pulses - p0) < 12 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        chk("reach_addr", {31'd0, ((sclk_pulses - p0) >= 12)}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("midrst_csn", {31'd0, spi_csn}, 32'd1);
        chk("midrst_sclk", {31'd0, spi_sclk}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_mosi", {31'd0, spi_mosi}, 32'd0);
        n_done = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) n_done++;
        end
        reset_n = 1'b1;
        repeat (2 * c_clk_div) begin
            @(negedge clk);
            if (done) n_done++;
        end
        chk("midrst_no_done", n_done, 0);
        run_txn(1'b0, 32'h0102_0304, 0);

        // random transactions
        for (int t = 0; t < 6; t++) begin
            fill_random($urandom_range(0, 5));
            run_txn(1'($urandom_range(0, 1)), $urandom, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_ram_master.md
# spi_ram_master

SPI master that issues RAM read/write transactions in the same framing the on-board SPI RAM slave accepts from the ESP32: command byte, big-endian address, optional dummy byte, then a data-byte stream. It lets on-FPGA logic (CPU-side loaders, test harnesses, a second board over gp/gn pins) act as the initiator of that protocol, with a simple byte handshake on the system side and SPI mode 0 on the pins.

## Interface
- c_addr_bits, 32, address width; multiple of 8, range 8..32
- c_clk_div, 4, clk cycles per SCLK half-period; ≥1
- clk  in  1  system clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request; sampled only when busy=0
- cmd_read  in  1  1 = read (cmd 0x01), 0 = write (cmd 0x00); sampled with start
- addr  in  c_addr_bits  target address; sampled with start
- len  in  16  data byte count; sampled with start; 0 = header-only
- tx_data  in  8  next write byte; sampled when tx_ready=1
- tx_ready  out  1  one-cycle pulse: tx_data loaded into shifter
- rx_data  out  8  last received read byte; held until next rx_valid
- rx_valid  out  1  one-cycle pulse: rx_data updated
- busy  out  1  transaction or CSn gap in progress
- done  out  1  one-cycle pulse when CSn deasserts
- spi_csn  out  1  chip select, active low
- spi_sclk  out  1  serial clock, idle low
- spi_mosi  out  1  master out, MSB first
- spi_miso  in  1  master in

## Operation
- States: IDLE, CMD, ADDR, DUMMY, DATA, END, GAP.
- IDLE: start=1 latches cmd_read, addr, len; next cycle csn=0, mosi=cmd bit 7, state CMD.
- CMD: 8 bits of 0x00/0x01. ADDR: c_addr_bits/8 bytes, MSB byte first. DUMMY (read only, see Configuration): 8 bits of 0x00 sent, MISO ignored.
- DATA, write: tx_data loaded into shifter at byte boundary, tx_ready pulses that cycle; first byte must be valid on tx_data when the header ends; caller has 8 bit periods to present the next byte. MISO ignored.
- DATA, read: mosi=0; 8 MISO samples shifted in MSB first; rx_data/rx_valid as in Timing.
- Byte counter decrements per data byte; after len bytes (or after header if len=0) → END.
- END: wait c_clk_div cycles after last falling edge, then csn=1, done pulse → GAP.
- GAP: csn held high 2*c_clk_div cycles, then busy=0 → IDLE.
- start while busy=1: ignored, no queuing.
- len counts full 16 bits: 0xFFFF = 65535 bytes.

## Timing
- Reset values: spi_csn=1, spi_sclk=0, spi_mosi=0, busy=0, done=0, tx_ready=0, rx_valid=0, rx_data=0x00, state IDLE.
- busy rises the cycle after start is sampled.
- SPI mode 0: SCLK rises c_clk_div cycles after csn falls / after previous falling edge; MISO sampled on the clk edge that raises SCLK; MOSI changes on the cycle SCLK falls.
- Bit period = 2*c_clk_div clk cycles; SCLK period likewise.
- Total SCLK pulses = 8*(1 + c_addr_bits/8 + D + len), D=1 for read with dummy enabled, else 0.
- rx_valid pulses the cycle after the rising edge that samples bit 0 of each data byte.
- tx_ready pulses on the same cycle the shifter loads (the falling edge ending the previous byte); MOSI shows bit 7 that cycle.
- Reset asserted mid-transaction: immediate (asynchronous) return to reset values; no done pulse; slave sees CSn rise.

## Configuration
- SPI_RAM_MASTER_DUMMY_EN defined: read transactions insert one 0x00 dummy byte after the address (slave read turnaround); writes unaffected.
- Undefined: no DUMMY state; read data sampling starts with the bit after the last address bit.

## Test plan
- c_clk_div=2, write addr 0x00004000 len=2 data 0xA5,0x3C → MOSI stream 00 00 00 40 00 A5 3C, 56 SCLK pulses, 2 tx_ready pulses, done once, busy low 4 cycles after csn rises.
- Read (dummy enabled) addr 0x00001234 len=3, slave model returns 0x11,0x22,0x33 → MOSI 01 00 00 12 34 00 00 00 00, 72 SCLK pulses, rx_valid ×3 with rx_data 0x11,0x22,0x33.
- Same read built without SPI_RAM_MASTER_DUMMY_EN → 64 SCLK pulses, same rx_data values.
- len=0 write to 0xFF000000 → 40 SCLK pulses, no tx_ready, done pulses.
- start pulsed during active transaction → ignored; byte counts and MOSI stream unchanged.
- reset_n low mid-ADDR → csn=1, sclk=0, busy=0 immediately, no done; next start runs a full clean transaction.
